seq_addsub: RTL
===============

Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor. Computes A+B+cin or A-B-bin over WIDTH bits.
- Reuses one DIGIT-bit adder slice per clock, least significant digit first, and registers the carry between digits.
- Sits beside the combinational ripple-carry adder/subtractor as its area-reduced, handshaked successor.
- Adds a runtime add/sub mode, signed overflow and zero flags, and start/ready/valid control.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥1.
- DIGIT, 4, bits processed per clock; WIDTH % DIGIT must be 0. N = WIDTH/DIGIT digit cycles.

Ports:
- i_w_clk  input  1  clock, rising edge.
- i_w_rst_n  input  1  asynchronous active-low reset.
- i_w_start  input  1  request; accepted only when o_w_ready=1.
- i_w_sub  input  1  0 = add, 1 = subtract; sampled at accept.
- i_w_A  input  WIDTH  operand A; sampled at accept.
- i_w_B  input  WIDTH  operand B; sampled at accept.
- i_w_carry_in  input  1  carry-in for add, borrow-in for subtract; sampled at accept.
- o_w_ready  output  1  high in IDLE.
- o_w_valid  output  1  one-cycle pulse when results update.
- o_w_result  output  WIDTH  sum or difference, held until the next completion.
- o_w_carry  output  1  add: carry-out; sub: true borrow-out (1 ⇔ A < B + bin, unsigned).
- o_w_overflow  output  1  two's-complement overflow.
- o_w_zero  output  1  o_w_result == 0.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - o_w_ready = 1; o_w_valid = 0; o_w_result = 0; o_w_carry = 0; o_w_overflow = 0; o_w_zero = 0.
  - Digit counter and internal carry are cleared. An in-flight operation is discarded with no partial valid.
- States:
  - IDLE → RUN on an edge where i_w_start = 1. Latch A, B, mode and cin; set counter = 0.
  - RUN → RUN while counter < N-1. RUN → DONE on the edge that processes digit N-1.
  - DONE → IDLE unconditionally after one cycle.
- Datapath:
  - Subtract computes A + ~B + ~bin. The internal carry seed is cin for add and ~bin for subtract.
  - Each RUN edge adds digit k of A and B' plus the carry register, stores the DIGIT result bits into slice k, and updates the carry register.
  - o_w_carry = final carry for add, ~final carry for subtract.
- Overflow: carry into the MSB XOR carry out of the MSB, taken on the final digit. This includes the effect of cin/bin.
- Zero: computed from the complete result.
- Timing:
  - Accept edge = edge 0. o_w_result, o_w_carry, o_w_overflow and o_w_zero update at edge N, and o_w_valid = 1 for exactly the cycle after edge N.
  - o_w_ready returns to 1 after edge N+1. Throughput is one operation per N+2 cycles.
- Simultaneous and boundary cases:
  - i_w_start in RUN or DONE is ignored, not queued.
  - Input changes after the accept edge have no effect.
  - With N = 1 (DIGIT = WIDTH), latency is 1 cycle with identical rules.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan (WIDTH=16, DIGIT=4, N=4 unless stated):
- Add: A=0x1234, B=0x0FFF, cin=0 → result 0x2233, carry 0, ovf 0, zero 0. o_w_valid high exactly 4 cycles after accept; ready low for cycles 1–5.
- Subtract with borrow-out: A=0x0005, B=0x0007, bin=0 → result 0xFFFE, carry(borrow) 1, ovf 0.
- Signed overflow on subtract: A=0x8000, B=0x0001, bin=0 → result 0x7FFF, borrow 0, ovf 1. Also A=0x0000, B=0x0000, bin=1 → 0xFFFF, borrow 1, ovf 0.
- Carry into zero: add A=0xFFFF, B=0x0000, cin=1 → result 0x0000, carry 1, zero 1, ovf 0. Add A=0x7FFF, B=0x0001 → 0x8000, ovf 1.
- Control:
  - Pulse i_w_start and change A/B during RUN → ignored; the first operation's result is unchanged and no extra valid appears.
  - Assert i_w_rst_n=0 mid-RUN (between clock edges) → all outputs 0 and ready 1 immediately; no valid after release.
  - A new start after release completes normally.
- Sweep: DIGIT ∈ {1,4,16} with 1000 random A, B, mode and cin, checked against a behavioural A±B±c model for result, carry, overflow, zero and latency N.

Source files
------------

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor. One DIGIT-bit adder slice is
// reused every clock, least significant digit first, with the inter-digit
// carry held in a register. Computes A+B+cin or A-B-bin over WIDTH bits.
//
// Ports:
//   i_w_clk        rising-edge clock
//   i_w_rst_n      asynchronous active-low reset
//   i_w_start      request, accepted only while o_w_ready=1
//   i_w_sub        0 = add, 1 = subtract (sampled at accept)
//   i_w_A, i_w_B   operands (sampled at accept)
//   i_w_carry_in   carry-in (add) / borrow-in (subtract), sampled at accept
//   o_w_ready      high in IDLE
//   o_w_valid      one-cycle pulse when the result registers have updated
//   o_w_result     sum or difference, held until the next completion
//   o_w_carry      add: carry-out; subtract: borrow-out
//   o_w_overflow   two's-complement overflow
//   o_w_zero       o_w_result == 0
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; outputs hold the last result
// RUN   | one digit processed per clock, counter = digit index
// DONE  | results updated on entry; o_w_valid high for this cycle
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_w_clk,
    input  logic             i_w_rst_n,
    input  logic             i_w_start,
    input  logic             i_w_sub,
    input  logic [WIDTH-1:0] i_w_A,
    input  logic [WIDTH-1:0] i_w_B,
    input  logic             i_w_carry_in,
    output logic             o_w_ready,
    output logic             o_w_valid,
    output logic [WIDTH-1:0] o_w_result,
    output logic             o_w_carry,
    output logic             o_w_overflow,
    output logic             o_w_zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, res_work, res_nxt;
    logic             sub_q, carry_q;
    logic [DIGIT:0]   dsum;
    logic             accept, last_dig, msb_cin;

    assign accept   = (state == IDLE) && i_w_start;
    assign last_dig = (cnt == CW'(N - 1));

    assign o_w_ready = (state == IDLE);
    assign o_w_valid = (state == DONE);

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_w_start) state_nxt = RUN;
            RUN:     if (last_dig) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are shifted right each digit so the slice always reads bit 0;
    // result digits enter at the top, so after N digits digit k sits in slice k.
    always_comb begin
        dsum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
        // Carry into the slice MSB recovered from its sum bit.
        msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
        res_nxt = (res_work >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            carry_q      <= 1'b0;
            cnt          <= '0;
            res_work     <= '0;
            o_w_result   <= '0;
            o_w_carry    <= 1'b0;
            o_w_overflow <= 1'b0;
            o_w_zero     <= 1'b0;
        end else if (accept) begin
            // Subtract is A + ~B + ~bin.
            a_q     <= i_w_A;
            b_q     <= i_w_sub ? ~i_w_B : i_w_B;
            sub_q   <= i_w_sub;
            carry_q <= i_w_sub ? ~i_w_carry_in : i_w_carry_in;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_q      <= a_q >> DIGIT;
            b_q      <= b_q >> DIGIT;
            carry_q  <= dsum[DIGIT];
            res_work <= res_nxt;
            cnt      <= cnt + CW'(1);
            if (last_dig) begin
                o_w_result   <= res_nxt;
                // Borrow-out is the inverted carry of A + ~B + ~bin.
                o_w_carry    <= dsum[DIGIT] ^ sub_q;
                o_w_overflow <= msb_cin ^ dsum[DIGIT];
                o_w_zero     <= (res_nxt == '0);
            end
        end
    end

endmodule
